cluster_chunk_loader: RTL and testbench

Parametrised sequencer that streams IFM and filter chunks from the IFM and filter SRAMs into the compute cluster's chunk buffers. It generalises the fixed two-buffer, single-filter-pass scheme to `BUF_NUM` slots, `CU_NUM` compute units and configurable chunk length. It sits between the layer controller, which issues jobs, and the memory-plus-cluster wrapper. It drives that wrapper's chunk-write, SRAM read-index and ready/select inputs.

---
 rtl/cluster_loader_pkg.sv | 25 ++
 rtl/cluster_chunk_loader_if.sv | 60 ++++++
 rtl/chunk_slot_tracker.sv | 67 ++++++
 rtl/cluster_chunk_loader.sv | 190 +++++++++++++++++++
 tb/tb_cluster_chunk_loader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cluster_loader_pkg.sv
// Shared types and helpers for the cluster chunk loader.
// Holds the FSM state enum, default sizes and width/wrap helpers.
package cluster_loader_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_IFM = 2'd1,
    LOAD_FIL = 2'd2
  } load_state_e;

  localparam int BEAT_NUM_DEF      = 8;
  localparam int IFM_CHUNK_NUM_DEF = 16;
  localparam int FIL_CHUNK_NUM_DEF = 32;
  localparam int CU_NUM_DEF        = 4;
  localparam int BUF_NUM_DEF       = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cluster_chunk_loader_if.sv
// Job/release handshake and chunk-write bus of the chunk loader.
// master = layer controller side, slave = loader side.
interface cluster_chunk_loader_if
  import cluster_loader_pkg::*;
#(
  parameter int BEAT_NUM      = BEAT_NUM_DEF,
  parameter int IFM_CHUNK_NUM = IFM_CHUNK_NUM_DEF,
  parameter int FIL_CHUNK_NUM = FIL_CHUNK_NUM_DEF,
  parameter int CU_NUM        = CU_NUM_DEF,
  parameter int BUF_NUM       = BUF_NUM_DEF
);
  localparam int BW = idx_w(BEAT_NUM);
  localparam int IW = idx_w(IFM_CHUNK_NUM);
  localparam int FW = idx_w(FIL_CHUNK_NUM);
  localparam int PW = idx_w(BUF_NUM);

  logic               job_valid_i;
  logic               job_ready_o;
  logic [IW-1:0]      job_ifm_base_i;
  logic [FW-1:0]      job_fil_base_i;
  logic               slot_release_i;
  logic               ifm_chunk_wr_valid_o;
  logic [BW-1:0]      ifm_chunk_wr_count_o;
  logic [PW-1:0]      ifm_chunk_wr_sel_o;
  logic [IW-1:0]      ifm_sram_rd_count_o;
  logic               fil_chunk_wr_valid_o;
  logic [BW-1:0]      fil_chunk_wr_count_o;
  logic [PW-1:0]      fil_chunk_wr_sel_o;
  logic [CU_NUM-1:0]  fil_chunk_cu_wr_sel_o;
  logic [FW-1:0]      fil_sram_rd_count_o;
  logic [PW-1:0]      chunk_rd_sel_o;
  logic [BUF_NUM-1:0] chunk_rdy_o;
  logic               busy_o;
  logic               err_o;

  modport master (
    output job_valid_i, job_ifm_base_i,
    output job_fil_base_i, slot_release_i,
    input  job_ready_o,
    input  ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o,
    input  ifm_chunk_wr_sel_o, ifm_sram_rd_count_o,
    input  fil_chunk_wr_valid_o, fil_chunk_wr_count_o,
    input  fil_chunk_wr_sel_o, fil_chunk_cu_wr_sel_o,
    input  fil_sram_rd_count_o,
    input  chunk_rd_sel_o, chunk_rdy_o, busy_o, err_o
  );

  modport slave (
    input  job_valid_i, job_ifm_base_i,
    input  job_fil_base_i, slot_release_i,
    output job_ready_o,
    output ifm_chunk_wr_valid_o, ifm_chunk_wr_count_o,
    output ifm_chunk_wr_sel_o, ifm_sram_rd_count_o,
    output fil_chunk_wr_valid_o, fil_chunk_wr_count_o,
    output fil_chunk_wr_sel_o, fil_chunk_cu_wr_sel_o,
    output fil_sram_rd_count_o,
    output chunk_rd_sel_o, chunk_rdy_o, busy_o, err_o
  );

endinterface

// File: rtl/chunk_slot_tracker.sv
// Slot ring bookkeeping: wr/rd pointers, occupancy, full flags, err.
// In: complete_i, release_i. Out: pointers, rdy_o, occ_next_o, err_o.
module chunk_slot_tracker
  import cluster_loader_pkg::*;
#(
  parameter int BUF_NUM = BUF_NUM_DEF,
  localparam int PW = idx_w(BUF_NUM),
  localparam int OW = $clog2(BUF_NUM + 1)
)(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               complete_i,
  input  logic               release_i,
  output logic [PW-1:0]      wr_ptr_o,
  output logic [PW-1:0]      rd_ptr_o,
  output logic [BUF_NUM-1:0] rdy_o,
  output logic [OW-1:0]      occ_next_o,
  output logic               err_o
);

  logic [PW-1:0]      wr_q, rd_q;
  logic [OW-1:0]      occ_q, occ_d;
  logic [BUF_NUM-1:0] rdy_q, rdy_d;
  logic               err_q;
  logic               rel_ok;

  // a release against an empty ring is dropped
  assign rel_ok = release_i && (occ_q != '0);

  always_comb begin
    rdy_d = rdy_q;
    occ_d = occ_q;
    if (complete_i) rdy_d[wr_q] = 1'b1;
    if (rel_ok) rdy_d[rd_q] = 1'b0;
    unique case ({complete_i, rel_ok})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      rdy_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      rdy_q <= rdy_d;
      if (complete_i)
        wr_q <= PW'(wrap_inc(int'(wr_q), BUF_NUM));
      if (rel_ok)
        rd_q <= PW'(wrap_inc(int'(rd_q), BUF_NUM));
      if (release_i && !rel_ok)
        err_q <= 1'b1;
    end
  end

  assign wr_ptr_o   = wr_q;
  assign rd_ptr_o   = rd_q;
  assign rdy_o      = rdy_q;
  assign occ_next_o = occ_d;
  assign err_o      = err_q;

endmodule

// File: rtl/cluster_chunk_loader.sv
// Streams one IFM chunk then per-CU filter chunks into a buffer slot.
// Ports: clk_i, rst_i (async low), bus (slave). Macro: FIL_BROADCAST_EN.
module cluster_chunk_loader
  import cluster_loader_pkg::*;
#(
  parameter int BEAT_NUM      = BEAT_NUM_DEF,
  parameter int IFM_CHUNK_NUM = IFM_CHUNK_NUM_DEF,
  parameter int FIL_CHUNK_NUM = FIL_CHUNK_NUM_DEF,
  parameter int CU_NUM        = CU_NUM_DEF,
  parameter int BUF_NUM       = BUF_NUM_DEF
)(
  input logic                   clk_i,
  input logic                   rst_i,
  cluster_chunk_loader_if.slave bus
);

  localparam int BW = idx_w(BEAT_NUM);
  localparam int IW = idx_w(IFM_CHUNK_NUM);
  localparam int FW = idx_w(FIL_CHUNK_NUM);
  localparam int CW = idx_w(CU_NUM);
  localparam int PW = idx_w(BUF_NUM);
  localparam int OW = $clog2(BUF_NUM + 1);

  load_state_e       state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [CW-1:0]     cu_q, cu_d;
  logic [FW-1:0]     fil_base_q;
  logic              last_beat, last_cu;
  logic              accept, done;
  logic [CU_NUM-1:0] cu_mask;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     occ_next;
  logic              err;
  logic [BUF_NUM-1:0] rdy;

  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              ifm_v_q, ifm_v_d;
  logic [BW-1:0]     ifm_cnt_q, ifm_cnt_d;
  logic [PW-1:0]     ifm_sel_q, ifm_sel_d;
  logic [IW-1:0]     ifm_idx_q, ifm_idx_d;
  logic              fil_v_q, fil_v_d;
  logic [BW-1:0]     fil_cnt_q, fil_cnt_d;
  logic [PW-1:0]     fil_sel_q, fil_sel_d;
  logic [FW-1:0]     fil_idx_q, fil_idx_d;
  logic [CU_NUM-1:0] cu_sel_q, cu_sel_d;

  assign accept    = bus.job_valid_i && ready_q;
  assign last_beat = (beat_q == BW'(BEAT_NUM - 1));

`ifdef FIL_BROADCAST_EN
  assign last_cu = 1'b1;
  assign cu_mask = '1;
`else
  assign last_cu = (cu_q == CW'(CU_NUM - 1));
  assign cu_mask = CU_NUM'(1) << cu_d;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      cu_q       <= '0;
      fil_base_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cu_q    <= cu_d;
      if (accept) fil_base_q <= bus.job_fil_base_i;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cu_d    = cu_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD_IFM;
          beat_d  = '0;
        end
      end
      LOAD_IFM: begin
        beat_d = beat_q + BW'(1);
        if (last_beat) begin
          state_d = LOAD_FIL;
          beat_d  = '0;
          cu_d    = '0;
        end
      end
      LOAD_FIL: begin
        beat_d = beat_q + BW'(1);
        if (last_beat) begin
          beat_d = '0;
          if (last_cu) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            cu_d = cu_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // next values of the registered outputs
  always_comb begin
    ifm_v_d   = (state_d == LOAD_IFM);
    fil_v_d   = (state_d == LOAD_FIL);
    busy_d    = (state_d != IDLE);
    ready_d   = (state_d == IDLE) && (occ_next < OW'(BUF_NUM));
    ifm_cnt_d = ifm_v_d ? beat_d : ifm_cnt_q;
    ifm_idx_d = accept ? bus.job_ifm_base_i : ifm_idx_q;
    ifm_sel_d = accept ? wr_ptr : ifm_sel_q;
    fil_cnt_d = fil_v_d ? beat_d : fil_cnt_q;
    fil_sel_d = fil_v_d ? wr_ptr : fil_sel_q;
    cu_sel_d  = fil_v_d ? cu_mask : '0;
    fil_idx_d = fil_idx_q;
    // filter index walks with the CU and wraps at the SRAM depth
    unique case (1'b1)
      (state_q == LOAD_IFM) && last_beat:
        fil_idx_d = fil_base_q;
      (state_q == LOAD_FIL) && last_beat && !last_cu:
        fil_idx_d = FW'(wrap_inc(int'(fil_idx_q), FIL_CHUNK_NUM));
      default:
        fil_idx_d = fil_idx_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      ifm_v_q   <= 1'b0;
      ifm_cnt_q <= '0;
      ifm_sel_q <= '0;
      ifm_idx_q <= '0;
      fil_v_q   <= 1'b0;
      fil_cnt_q <= '0;
      fil_sel_q <= '0;
      fil_idx_q <= '0;
      cu_sel_q  <= '0;
    end else begin
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      ifm_v_q   <= ifm_v_d;
      ifm_cnt_q <= ifm_cnt_d;
      ifm_sel_q <= ifm_sel_d;
      ifm_idx_q <= ifm_idx_d;
      fil_v_q   <= fil_v_d;
      fil_cnt_q <= fil_cnt_d;
      fil_sel_q <= fil_sel_d;
      fil_idx_q <= fil_idx_d;
      cu_sel_q  <= cu_sel_d;
    end
  end

  chunk_slot_tracker #(
    .BUF_NUM (BUF_NUM)
  ) u_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .complete_i (done),
    .release_i  (bus.slot_release_i),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .rdy_o      (rdy),
    .occ_next_o (occ_next),
    .err_o      (err)
  );

  assign bus.job_ready_o           = ready_q;
  assign bus.busy_o                = busy_q;
  assign bus.ifm_chunk_wr_valid_o  = ifm_v_q;
  assign bus.ifm_chunk_wr_count_o  = ifm_cnt_q;
  assign bus.ifm_chunk_wr_sel_o    = ifm_sel_q;
  assign bus.ifm_sram_rd_count_o   = ifm_idx_q;
  assign bus.fil_chunk_wr_valid_o  = fil_v_q;
  assign bus.fil_chunk_wr_count_o  = fil_cnt_q;
  assign bus.fil_chunk_wr_sel_o    = fil_sel_q;
  assign bus.fil_chunk_cu_wr_sel_o = cu_sel_q;
  assign bus.fil_sram_rd_count_o   = fil_idx_q;
  assign bus.chunk_rd_sel_o        = rd_ptr;
  assign bus.chunk_rdy_o           = rdy;
  assign bus.err_o                 = err;

endmodule

// File: tb/tb_cluster_chunk_loader.sv
// Bench for cluster_chunk_loader: directed scenarios then random traffic.
// Expected values come from a timeline/queue model of slot usage.
module tb_cluster_chunk_loader;

  localparam int B   = 4;
  localparam int CU  = 2;
  localparam int NB  = 2;
  localparam int FN  = 8;
  localparam int IN  = 16;
`ifdef FIL_BROADCAST_EN
  localparam int NPH = 1;
  localparam bit BC  = 1'b1;
`else
  localparam int NPH = CU;
  localparam bit BC  = 1'b0;
`endif
  localparam int LAST = B * (NPH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cluster_chunk_loader_if #(
    .BEAT_NUM(B), .IFM_CHUNK_NUM(IN), .FIL_CHUNK_NUM(FN),
    .CU_NUM(CU), .BUF_NUM(NB)
  ) bus ();

  cluster_chunk_loader #(
    .BEAT_NUM(B), .IFM_CHUNK_NUM(IN), .FIL_CHUNK_NUM(FN),
    .CU_NUM(CU), .BUF_NUM(NB)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  bit m_busy, m_ready, m_err;
  int m_d, m_slot, m_ib, m_fb, m_rd, m_wr;
  int q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ready = 0; m_err = 0;
    m_d = 0; m_rd = 0; m_wr = 0;
    q.delete();
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_ready"}, 32'(bus.job_ready_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_ifm_v"}, 32'(bus.ifm_chunk_wr_valid_o), 0);
    chk({tag, "_ifm_cnt"}, 32'(bus.ifm_chunk_wr_count_o), 0);
    chk({tag, "_ifm_idx"}, 32'(bus.ifm_sram_rd_count_o), 0);
    chk({tag, "_fil_v"}, 32'(bus.fil_chunk_wr_valid_o), 0);
    chk({tag, "_fil_idx"}, 32'(bus.fil_sram_rd_count_o), 0);
    chk({tag, "_cu_sel"}, 32'(bus.fil_chunk_cu_wr_sel_o), 0);
    chk({tag, "_rdy"}, 32'(bus.chunk_rdy_o), 0);
    chk({tag, "_rd_sel"}, 32'(bus.chunk_rd_sel_o), 0);
    chk({tag, "_err"}, 32'(bus.err_o), 0);
  endtask

  task automatic check_all();
    bit iv, fv;
    int k, o, rdy;
    iv = m_busy && (m_d <= B);
    fv = m_busy && (m_d > B);
    chk("ifm_v", 32'(bus.ifm_chunk_wr_valid_o), 32'(iv));
    if (iv) begin
      chk("ifm_cnt", 32'(bus.ifm_chunk_wr_count_o), m_d - 1);
      chk("ifm_idx", 32'(bus.ifm_sram_rd_count_o), m_ib);
      chk("ifm_sel", 32'(bus.ifm_chunk_wr_sel_o), m_slot);
    end
    chk("fil_v", 32'(bus.fil_chunk_wr_valid_o), 32'(fv));
    k = 0;
    if (fv) begin
      k = (m_d - B - 1) / B;
      o = (m_d - B - 1) % B;
      chk("fil_cnt", 32'(bus.fil_chunk_wr_count_o), o);
      chk("fil_idx", 32'(bus.fil_sram_rd_count_o),
          BC ? m_fb : (m_fb + k) % FN);
      chk("fil_sel", 32'(bus.fil_chunk_wr_sel_o), m_slot);
    end
    chk("cu_sel", 32'(bus.fil_chunk_cu_wr_sel_o),
        !fv ? 0 : (BC ? (1 << CU) - 1 : 1 << k));
    chk("busy", 32'(bus.busy_o), 32'(m_busy));
    chk("ready", 32'(bus.job_ready_o), 32'(m_ready));
    rdy = 0;
    foreach (q[i]) rdy |= 1 << q[i];
    chk("chunk_rdy", 32'(bus.chunk_rdy_o), rdy);
    chk("rd_sel", 32'(bus.chunk_rd_sel_o), m_rd);
    chk("err", 32'(bus.err_o), 32'(m_err));
  endtask

  task automatic step(input bit jv, input bit rel,
                      input int ib, input int fb);
    bit acc, cmp;
    bus.job_valid_i    = jv;
    bus.slot_release_i = rel;
    bus.job_ifm_base_i = 4'(ib);
    bus.job_fil_base_i = 3'(fb);
    @(posedge clk);
    acc = jv && m_ready;
    cmp = 0;
    if (m_busy) begin
      m_d++;
      if (m_d == LAST + 1) begin
        cmp = 1;
        m_busy = 0;
      end
    end
    if (rel) begin
      if (q.size() > 0) begin
        void'(q.pop_front());
        m_rd = (m_rd + 1) % NB;
      end else begin
        m_err = 1;
      end
    end
    if (cmp) begin
      q.push_back(m_wr);
      m_wr = (m_wr + 1) % NB;
    end
    if (acc) begin
      m_busy = 1; m_d = 1; m_slot = m_wr;
      m_ib = ib; m_fb = fb;
    end
    m_ready = !m_busy && (q.size() < NB);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic job(input int ib, input int fb);
    int n;
    n = 0;
    while (!m_ready && n < 40) begin
      step(0, 0, 0, 0);
      n++;
    end
    chk("job_wait_timeout", 32'(n < 40), 1);
    step(1, 0, ib, fb);
  endtask

  initial begin
    bus.job_valid_i    = 1'b0;
    bus.slot_release_i = 1'b0;
    bus.job_ifm_base_i = '0;
    bus.job_fil_base_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    zero_check("reset");
    rst_n = 1'b1;
    idle(2);

    job(3, 5);
    idle(LAST);
    chk("single_rdy", 32'(bus.chunk_rdy_o), 1);
    chk("single_rd_sel", 32'(bus.chunk_rd_sel_o), 0);
    chk("single_ready", 32'(bus.job_ready_o), 1);

    job(2, 7);
    idle(LAST);
    chk("full_rdy", 32'(bus.chunk_rdy_o), 3);
    chk("full_ready", 32'(bus.job_ready_o), 0);

    step(0, 1, 0, 0);
    chk("rel_rdy", 32'(bus.chunk_rdy_o), 2);
    chk("rel_rd_sel", 32'(bus.chunk_rd_sel_o), 1);
    chk("rel_ready", 32'(bus.job_ready_o), 1);

    job(5, 1);
    idle(LAST - 1);
    step(0, 1, 0, 0);
    chk("coin_rdy", 32'(bus.chunk_rdy_o), 1);
    chk("coin_rd_sel", 32'(bus.chunk_rd_sel_o), 0);
    chk("coin_err", 32'(bus.err_o), 0);

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    idle(3);
    chk("empty_err", 32'(bus.err_o), 1);
    chk("empty_rd_sel", 32'(bus.chunk_rd_sel_o), 1);
    chk("empty_rdy", 32'(bus.chunk_rdy_o), 0);

    job(9, 2);
    idle(B + 2);
    rst_n = 1'b0;
    #1;
    zero_check("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    zero_check("held_rst");
    rst_n = 1'b1;
    idle(1);
    job(4, 6);
    chk("post_rst_sel", 32'(bus.ifm_chunk_wr_sel_o), 0);
    idle(LAST);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, IN - 1)),
           int'($urandom_range(0, FN - 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
